// File: rtl/multi_ch_timer_intr_if.sv
// Control/status bus of the multi-channel timer: run/clear controls, per-channel
// configuration and the counter/interrupt status returned by the unit.
interface multi_ch_timer_intr_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NCH     = 4,
  parameter int unsigned PRESC_W = 8
);
  logic                 cnt_en;
  logic                 cnt_clr;
  logic [PRESC_W-1:0]   presc;
  logic [NCH-1:0]       ch_en;
  logic [NCH-1:0]       ch_mode;
  logic [NCH*WIDTH-1:0] limit;
  logic [NCH-1:0]       irq_clr;
  logic [WIDTH-1:0]     count;
  logic [NCH-1:0]       int_vec;
  logic                 int_any;
  logic                 ovf;

  modport master (
    output cnt_en, cnt_clr, presc, ch_en, ch_mode, limit, irq_clr,
    input  count, int_vec, int_any, ovf
  );

  modport slave (
    input  cnt_en, cnt_clr, presc, ch_en, ch_mode, limit, irq_clr,
    output count, int_vec, int_any, ovf
  );
endinterface

// File: rtl/multi_ch_timer_intr.sv
// Prescaled free-running counter with NCH compare channels (one-shot or periodic)
// raising sticky write-1-clear interrupt flags.
module multi_ch_timer_intr #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NCH     = 4,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_ch_timer_intr_if.slave  bus
);

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_DONE  = 2'd2
  } ch_state_t;

  logic [PRESC_W-1:0] psc;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_nxt;
  logic               ovf_q;
  logic               tick;
  logic [NCH-1:0]     en_q;
  logic [NCH-1:0]     int_q;
  logic [NCH-1:0]     hit;
  logic [WIDTH-1:0]   lim [NCH];
  logic [WIDTH-1:0]   tgt [NCH];
  ch_state_t          st  [NCH];

  assign tick      = bus.cnt_en & (psc == bus.presc);
  assign count_nxt = count_q + WIDTH'(1);

  // Comparing against count+1 lets the flag rise on the same edge the counter
  // reaches the target; equality on the wrapped sum handles target wrap.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      lim[i] = bus.limit[i*WIDTH +: WIDTH];
      hit[i] = (st[i] == CH_ARMED) & tick & ~bus.cnt_clr &
               (lim[i] != '0) & (count_nxt == tgt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.cnt_clr) begin
      psc     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (tick) begin
      psc     <= '0;
      count_q <= count_nxt;
      if (count_q == '1)
        ovf_q <= 1'b1;
    end else if (bus.cnt_en) begin
      psc <= psc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q  <= '0;
      int_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        st[i]  <= CH_IDLE;
        tgt[i] <= '0;
      end
    end else begin
      en_q  <= bus.ch_en;
      int_q <= (int_q & ~bus.irq_clr) | hit;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!bus.ch_en[i]) begin
          st[i] <= CH_IDLE;
        end else begin
          unique case (st[i])
            CH_IDLE: begin
              if (!en_q[i]) begin
                st[i]  <= CH_ARMED;
                tgt[i] <= bus.cnt_clr ? lim[i] : count_q + lim[i];
              end
            end
            CH_ARMED: begin
              if (bus.cnt_clr) begin
                tgt[i] <= lim[i];
              end else if (hit[i]) begin
                if (bus.ch_mode[i])
                  tgt[i] <= tgt[i] + lim[i];
                else
                  st[i] <= CH_DONE;
              end
            end
            CH_DONE: ;
            default: st[i] <= CH_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.int_vec = int_q;
  assign bus.int_any = |int_q;
  assign bus.ovf     = ovf_q;

endmodule
